ysyx_mem_arbiter: RTL and testbench

Shares the single simulated memory port between instruction fetch (IF) and the load/store unit (LSU) of the ysyx core, replacing direct DPI-C access from both stages. It accepts one transaction at a time over valid/ready request and response channels and forwards it to the memory port. Fixed LSU-over-IF priority applies, with a streak limit so IF cannot starve. It sits between the fetch/LSU stages and the memory/bus adapter.

---
 rtl/ysyx_arb_pkg.sv | 20 ++
 rtl/ysyx_arb_pick.sv | 35 +++
 rtl/ysyx_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_arb_pkg.sv
// Shared encodings and widths for the IF/LSU memory arbiter.
package ysyx_arb_pkg;
  // Core word length; address and data buses are sized from it.
  localparam int X_LEN      = 64;
  localparam int ARB_ADDR_W = X_LEN;
  localparam int ARB_DATA_W = X_LEN;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;
  localparam int STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;
endpackage

// File: rtl/ysyx_arb_pick.sv
// Combinational grant selection between IF and LSU.
// ARB_ROUND_ROBIN_EN selects alternating tie-break instead of LSU priority with streak limit.
module ysyx_arb_pick
  import ysyx_arb_pkg::*;
`ifndef ARB_ROUND_ROBIN_EN
#(
  parameter int MAX_LSU_STREAK = 4
)
`endif
(
  input  logic                i_if_valid,
  input  logic                i_lsu_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic                i_last_lsu,
`else
  input  logic [STREAK_W-1:0] i_streak,
`endif
  output logic                o_grant_if,
  output logic                o_grant_lsu
);

  logic w_tie_lsu;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_tie_lsu = ~i_last_lsu;
`else
  localparam logic [STREAK_W-1:0] LP_MAX = STREAK_W'(MAX_LSU_STREAK);
  // IF is forced once LSU has won MAX_LSU_STREAK ties in a row.
  assign w_tie_lsu = (i_streak != LP_MAX);
`endif

  assign o_grant_lsu = i_lsu_valid & (~i_if_valid | w_tie_lsu);
  assign o_grant_if  = i_if_valid & ~o_grant_lsu;

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Single-outstanding arbiter sharing the memory port between IF and LSU.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating tie-break).
module ysyx_mem_arbiter
  import ysyx_arb_pkg::*;
#(
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  input  logic                if_resp_ready,
  output logic [DATA_W-1:0]   if_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                busy,
  output logic                owner
);

  arb_state_e           r_state;
  arb_state_e           w_next;
  arb_owner_e           r_owner;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_wen;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W/8-1:0]  r_wmask;
  logic                 w_grant_if;
  logic                 w_grant_lsu;
  logic                 w_hs_if;
  logic                 w_hs_lsu;
  logic                 w_owner_rdy;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_lsu;

  ysyx_arb_pick u_pick (
    .i_if_valid  (if_req_valid),
    .i_lsu_valid (lsu_req_valid),
    .i_last_lsu  (r_last_lsu),
    .o_grant_if  (w_grant_if),
    .o_grant_lsu (w_grant_lsu)
  );

  // Last-owner starts as LSU so IF wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_lsu <= 1'b1;
    end else if (w_hs_if || w_hs_lsu) begin
      r_last_lsu <= w_hs_lsu;
    end
  end
`else
  localparam logic [STREAK_W-1:0] LP_MAX = STREAK_W'(MAX_LSU_STREAK);
  logic [STREAK_W-1:0] r_streak;

  ysyx_arb_pick #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_pick (
    .i_if_valid  (if_req_valid),
    .i_lsu_valid (lsu_req_valid),
    .i_streak    (r_streak),
    .o_grant_if  (w_grant_if),
    .o_grant_lsu (w_grant_lsu)
  );

  // Counts LSU wins while IF is waiting; any uncontested grant restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (w_hs_lsu) begin
      if (!if_req_valid)          r_streak <= '0;
      else if (r_streak != LP_MAX) r_streak <= r_streak + 4'd1;
    end else if (w_hs_if) begin
      r_streak <= '0;
    end
  end
`endif

  assign w_hs_if     = (r_state == IDLE) & w_grant_if;
  assign w_hs_lsu    = (r_state == IDLE) & w_grant_lsu;
  assign w_owner_rdy = (r_owner == OWN_LSU) ? lsu_resp_ready : if_resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs_if || w_hs_lsu)            w_next = REQ;
      REQ:     if (mem_req_ready)                  w_next = RESP;
      RESP:    if (mem_resp_valid && w_owner_rdy)  w_next = IDLE;
      default:                                     w_next = IDLE;
    endcase
  end

  // Request readies are gated by rst so nothing looks accepted during reset.
  always_comb begin
    if_req_ready   = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    if_resp_valid  = 1'b0;
    lsu_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if_req_ready  = rst & w_grant_if;
        lsu_req_ready = rst & w_grant_lsu;
      end
      REQ:  mem_req_valid = 1'b1;
      RESP: begin
        mem_resp_ready = w_owner_rdy;
        if_resp_valid  = (r_owner == OWN_IF)  & mem_resp_valid;
        lsu_resp_valid = (r_owner == OWN_LSU) & mem_resp_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_hs_lsu) begin
      r_owner <= OWN_LSU;
      r_addr  <= lsu_req_addr;
      r_wen   <= lsu_req_wen;
      r_wdata <= lsu_req_wdata;
      r_wmask <= lsu_req_wmask;
    end else if (w_hs_if) begin
      r_owner <= OWN_IF;
      r_addr  <= if_req_addr;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end
  end

  assign mem_req_addr   = r_addr;
  assign mem_req_wen    = r_wen;
  assign mem_req_wdata  = r_wdata;
  assign mem_req_wmask  = r_wmask;
  assign if_resp_rdata  = mem_resp_rdata;
  assign lsu_resp_rdata = mem_resp_rdata;
  assign busy           = (r_state != IDLE);
  assign owner          = r_owner;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Self-checking bench for ysyx_mem_arbiter: vector table, corner sequences, randomized model check.
module tb_ysyx_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid, if_resp_ready;
  logic [63:0] if_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [63:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [63:0] mem_resp_rdata;
  logic        busy, owner;

  int n_chk  = 0;
  int n_fail = 0;

  int m_streak;
  bit m_last_lsu;

  typedef struct {
    bit          iv;
    bit          lv;
    logic [63:0] ia;
    logic [63:0] la;
    bit          lw;
    logic [63:0] lwd;
    logic [7:0]  lm;
    int          rq_dly;
    int          rs_dly;
    int          rdy_dly;
    logic [63:0] rd;
    bit          exp_lsu;
    bit          exp_wen;
    logic [7:0]  exp_wmask;
  } vec_t;

  vec_t vec[6];
  bit   ord[10];

  ysyx_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MAX_LSU_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_rdata(if_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; if_req_addr = 0; if_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    tick();
    tick();
    rst = 1;
    tick();
    m_streak   = 0;
    m_last_lsu = 1'b1;
  endtask

  // Grant predicted from the arbitration rules; caller is at IDLE.
  function automatic bit model_pick(input bit iv, input bit lv);
    if (iv && !lv) return 1'b0;
    if (lv && !iv) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !m_last_lsu;
`else
    return (m_streak != MAXS);
`endif
  endfunction

  task automatic model_update(input bit iv, input bit g_lsu);
    m_last_lsu = g_lsu;
    if (g_lsu && iv) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
    else             m_streak = 0;
  endtask

  // One full transaction from IDLE back to IDLE; returns at posedge+1 in IDLE.
  task automatic txn(input vec_t v, input string tag);
    logic [63:0] ea;
    bit ow_vld, ow_rdy;
    if_req_valid = v.iv; if_req_addr = v.ia;
    lsu_req_valid = v.lv; lsu_req_addr = v.la; lsu_req_wen = v.lw;
    lsu_req_wdata = v.lwd; lsu_req_wmask = v.lm;
    mem_req_ready = 0; mem_resp_valid = 0; if_resp_ready = 0; lsu_resp_ready = 0;
    @(negedge clk);
    chk({tag, " if_req_ready"}, if_req_ready, !v.exp_lsu);
    chk({tag, " lsu_req_ready"}, lsu_req_ready, v.exp_lsu);
    chk({tag, " idle busy"}, busy, 0);
    tick();
    if_req_valid = 0; lsu_req_valid = 0;
    if_req_addr = ~v.ia; lsu_req_addr = ~v.la; lsu_req_wen = ~v.lw;
    lsu_req_wdata = ~v.lwd; lsu_req_wmask = ~v.lm;
    ea = v.exp_lsu ? v.la : v.ia;
    for (int c = 0; c <= v.rq_dly; c++) begin
      mem_req_ready = (c == v.rq_dly);
      @(negedge clk);
      chk({tag, " mem_req_valid"}, mem_req_valid, 1);
      chk({tag, " mem_req_addr"}, mem_req_addr, ea);
      chk({tag, " mem_req_wen"}, mem_req_wen, v.exp_wen);
      chk({tag, " mem_req_wmask"}, mem_req_wmask, v.exp_wmask);
      if (v.exp_lsu) chk({tag, " mem_req_wdata"}, mem_req_wdata, v.lwd);
      chk({tag, " owner"}, owner, v.exp_lsu);
      chk({tag, " req mem_resp_ready"}, mem_resp_ready, 0);
      tick();
    end
    mem_req_ready = 0;
    mem_resp_rdata = v.rd;
    for (int c = 0; c <= 16; c++) begin
      ow_vld = (c >= v.rs_dly);
      ow_rdy = (c >= v.rdy_dly);
      mem_resp_valid = ow_vld;
      if (v.exp_lsu) begin lsu_resp_ready = ow_rdy; if_resp_ready = !ow_rdy; end
      else           begin if_resp_ready = ow_rdy; lsu_resp_ready = !ow_rdy; end
      @(negedge clk);
      chk({tag, " mem_resp_ready"}, mem_resp_ready, ow_rdy);
      chk({tag, " if_resp_valid"}, if_resp_valid, ow_vld && !v.exp_lsu);
      chk({tag, " lsu_resp_valid"}, lsu_resp_valid, ow_vld && v.exp_lsu);
      if (ow_vld) begin
        chk({tag, " if_resp_rdata"}, if_resp_rdata, v.rd);
        chk({tag, " lsu_resp_rdata"}, lsu_resp_rdata, v.rd);
      end
      tick();
      if (ow_vld && ow_rdy) break;
    end
    mem_resp_valid = 0; if_resp_ready = 0; lsu_resp_ready = 0;
    chk({tag, " done busy"}, busy, 0);
  endtask

  initial begin
    vec_t v;
    bit iv, lv, g;

    // Reset state, with requests and a response deliberately asserted.
    clear_inputs();
    rst = 0;
    if_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst if_req_ready", if_req_ready, 0);
    chk("rst lsu_req_ready", lsu_req_ready, 0);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_resp_ready", mem_resp_ready, 0);
    chk("rst if_resp_valid", if_resp_valid, 0);
    chk("rst lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst owner", owner, 0);
    chk("rst mem_req_addr", mem_req_addr, 0);
    chk("rst mem_req_wen", mem_req_wen, 0);
    chk("rst mem_req_wdata", mem_req_wdata, 0);
    chk("rst mem_req_wmask", mem_req_wmask, 0);
    do_reset();

    // iv lv ia la lw lwd lm rq rs rdy rd exp_lsu exp_wen exp_wmask
    vec[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 8'h00, 0, 0, 0,
               64'h13, 1'b0, 1'b0, 8'h00};
    vec[1] = '{1'b0, 1'b1, 64'h0, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3, 1, 0,
               64'h0, 1'b1, 1'b1, 8'h0F};
    vec[2] = '{1'b0, 1'b1, 64'h0, 64'h8000_2008, 1'b0, 64'h5555, 8'hFF, 1, 2, 0,
               64'h1122_3344_5566_7788, 1'b1, 1'b0, 8'hFF};
    vec[3] = '{1'b1, 1'b0, 64'h8000_0004, 64'h0, 1'b0, 64'h0, 8'h00, 0, 2, 3,
               64'h0010_0093, 1'b0, 1'b0, 8'h00};
    vec[4] = '{1'b1, 1'b0, 64'h8000_0008, 64'h1234, 1'b1, 64'hFFFF, 8'hFF, 2, 0, 0,
               64'hCAFE, 1'b0, 1'b0, 8'h00};
    vec[5] = '{1'b0, 1'b1, 64'h0, 64'h8000_1FF8, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 8'h80, 0, 0, 2,
               64'h77, 1'b1, 1'b1, 8'h80};
    for (int i = 0; i < 6; i++) txn(vec[i], $sformatf("vec%0d", i));

    // Both requesters valid for ten consecutive grants.
`ifdef ARB_ROUND_ROBIN_EN
    ord = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    do_reset();
    for (int k = 0; k < 10; k++) begin
      v = '{1'b1, 1'b1, 64'h8000_0100 + 64'(k * 4), 64'h9000_0000 + 64'(k * 8), 1'(k), 64'(k * 3),
            8'hFF, 0, 0, 0, 64'(k), ord[k], ord[k] & 1'(k), ord[k] ? 8'hFF : 8'h00};
      txn(v, $sformatf("tie%0d", k));
    end

    // Owner backpressure holds RESP while IF waits.
    do_reset();
    lsu_req_valid = 1; lsu_req_addr = 64'h8000_3000; lsu_req_wen = 0;
    @(negedge clk);
    chk("bp lsu_req_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0;
    if_req_valid = 1; if_req_addr = 64'h8000_0040;
    mem_req_ready = 1;
    @(negedge clk);
    chk("bp req if_req_ready", if_req_ready, 0);
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_rdata = 64'hAB; lsu_resp_ready = 0; if_resp_ready = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp mem_resp_ready", mem_resp_ready, 0);
      chk("bp if_req_ready", if_req_ready, 0);
      chk("bp lsu_resp_valid", lsu_resp_valid, 1);
      chk("bp if_resp_valid", if_resp_valid, 0);
      chk("bp busy", busy, 1);
      tick();
    end
    lsu_resp_ready = 1;
    @(negedge clk);
    chk("bp release mem_resp_ready", mem_resp_ready, 1);
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 0; if_resp_ready = 0;
    v = '{1'b1, 1'b0, 64'h8000_0040, 64'h0, 1'b0, 64'h0, 8'h00, 0, 0, 0,
          64'h99, 1'b0, 1'b0, 8'h00};
    txn(v, "bp if");

    // Asynchronous reset while in REQ.
    if_req_valid = 1; if_req_addr = 64'h8000_0080;
    @(negedge clk);
    chk("arst if_req_ready", if_req_ready, 1);
    tick();
    if_req_valid = 0;
    @(negedge clk);
    chk("arst pre mem_req_valid", mem_req_valid, 1);
    #2;
    rst = 0;
    #1;
    chk("arst mem_req_valid", mem_req_valid, 0);
    chk("arst busy", busy, 0);
    chk("arst mem_req_addr", mem_req_addr, 0);
    tick();
    rst = 1;
    tick();
    m_streak = 0; m_last_lsu = 1'b1;
    v = '{1'b1, 1'b0, 64'h8000_00C0, 64'h0, 1'b0, 64'h0, 8'h00, 1, 1, 0,
          64'h4242, 1'b0, 1'b0, 8'h00};
    txn(v, "arst if");

    // Spurious memory response while idle.
    mem_resp_valid = 1; mem_resp_rdata = 64'hBAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spur mem_resp_ready", mem_resp_ready, 0);
      chk("spur if_resp_valid", if_resp_valid, 0);
      chk("spur lsu_resp_valid", lsu_resp_valid, 0);
      chk("spur busy", busy, 0);
      tick();
    end
    mem_resp_valid = 0;

    // Randomized traffic against the rule-level model.
    do_reset();
    for (int k = 0; k < 120; k++) begin
      iv = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) != 0);
      if (!iv && !lv) begin
        clear_inputs();
        @(negedge clk);
        chk("rand idle if_req_ready", if_req_ready, 0);
        chk("rand idle lsu_req_ready", lsu_req_ready, 0);
        tick();
        continue;
      end
      g = model_pick(iv, lv);
      v.iv = iv; v.lv = lv;
      v.ia = {$urandom, $urandom}; v.la = {$urandom, $urandom};
      v.lw = 1'($urandom); v.lwd = {$urandom, $urandom}; v.lm = 8'($urandom);
      v.rq_dly = $urandom_range(0, 3); v.rs_dly = $urandom_range(0, 3);
      v.rdy_dly = $urandom_range(0, 3); v.rd = {$urandom, $urandom};
      v.exp_lsu = g; v.exp_wen = g & v.lw; v.exp_wmask = g ? v.lm : 8'h00;
      txn(v, $sformatf("rand%0d", k));
      model_update(iv, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
